ctrl_pipe_regs: RTL and testbench
=================================

Name: ctrl_pipe_regs

Overview:
- Producer end of the decode-stage hazard/forwarding interface. Registers ID-stage control bits through the EXE, MEM and WB pipeline stages.
- Returns the EXE_/MEM_ RegWrite, mem_to_reg and writereg_num signals that the ID-stage control unit uses for stall and forwarding decisions.
- Resolves the destination register number from the rd/rt/$31 select code.
- Inserts a bubble into EXE on stall or flush, and counts stall cycles.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ID_RegWrite  in  1  decoded register-write enable, already gated by nostall
- ID_mem_to_reg  in  1  writeback source is data memory (load)
- ID_memwrite  in  1  data-memory write enable
- ID_jal  in  1  writeback value is the link PC
- ID_writereg_to_rt  in  2  destination select: 00 rd, 01 rt, 10 $31, 11 reserved
- ID_rd  in  5  instruction rd field
- ID_rt  in  5  instruction rt field
- ID_aluOp  in  4  ALU operation
- ID_alua  in  1  ALU A selects shamt
- ID_alub  in  1  ALU B selects extended immediate
- ID_nostall  in  1  0 = load-use stall this cycle
- ID_flush  in  1  1 = squash the instruction leaving ID
- EXE_RegWrite, EXE_mem_to_reg, EXE_memwrite, EXE_jal, EXE_alua, EXE_alub  out  1 each  EXE-stage control
- EXE_aluOp  out  4  EXE-stage ALU op
- EXE_writereg_num  out  5  EXE-stage destination
- MEM_RegWrite, MEM_mem_to_reg, MEM_memwrite, MEM_jal  out  1 each  MEM-stage control
- MEM_writereg_num  out  5  MEM-stage destination
- WB_RegWrite, WB_mem_to_reg, WB_jal  out  1 each  WB-stage control
- WB_writereg_num  out  5  WB-stage destination
- IFID_we  out  1  PC / IF-ID register write enable
- stall_cnt  out  CNT_W  cumulative stall cycles

Behaviour:
- Clocking and reset:
  - All outputs except IFID_we are registers updated on the rising edge of clk.
  - rst=1 at an edge clears every registered output to 0. This includes stall_cnt and all writereg_num fields.
  - rst takes priority over every other input. Reset mid-stall discards the bubble and counter state; the pipeline restarts empty.
- Stall signal:
  - IFID_we = ID_nostall (combinational).
  - IFID_we is 1 while rst is held only if ID_nostall=1; upstream reset governs the IF stage.
- Destination decode, combinational from ID inputs:
  - 00 → ID_rd; 01 → ID_rt; 10 → 5'd31.
  - 11 → 5'd0, and the registered RegWrite is forced to 0.
- EXE load, per edge with rst=0:
  - If ID_flush=1 or ID_nostall=0, EXE takes a bubble: all EXE_ outputs = 0, including EXE_mem_to_reg and EXE_writereg_num.
  - A bubble never leaves mem_to_reg set with RegWrite clear.
  - Otherwise EXE_* ← ID_* and EXE_writereg_num ← decoded number.
  - EXE_RegWrite ← ID_RegWrite & (decoded number != 0). A write to $0 is registered as no write, with writereg_num still 0.
  - Flush and stall together produce a single bubble, identical to either alone.
- MEM and WB advance unconditionally every cycle; a stall does not freeze them.
  - MEM ← EXE for RegWrite, mem_to_reg, memwrite, jal and writereg_num.
  - WB ← MEM for RegWrite, mem_to_reg, jal and writereg_num.
  - ALU fields terminate at EXE.
- Latency: ID → EXE 1 cycle, → MEM 2 cycles, → WB 3 cycles.
- Stall counter:
  - stall_cnt increments by 1 on each edge where rst=0 and ID_nostall=0.
  - ID_flush does not count.
  - It saturates at 2^CNT_W−1 and holds there; it never wraps.
- Ordering: all stage transfers use old register values (non-blocking). A simultaneous stall plus valid MEM/WB data still drains MEM→WB that same edge.

Test Plan:
1. Reset: hold rst 2 cycles with arbitrary inputs → all outputs 0, stall_cnt=0. Then issue a single ID_RegWrite=1, rd=5, sel=00 → EXE_writereg_num=5 at +1, MEM at +2, WB at +3, with RegWrite following.
2. Destination decode: sel=01 with rt=9 → 9; sel=10 → 31; sel=11 with ID_RegWrite=1 → EXE_RegWrite=0, num=0. Then rd=0, sel=00, RegWrite=1 → EXE_RegWrite=0.
3. Load-use stall: issue a load (mem_to_reg=1, rt=8, sel=01), next cycle drive ID_nostall=0 →
   - IFID_we=0 that cycle.
   - EXE bubble (EXE_RegWrite=0, EXE_mem_to_reg=0, num=0).
   - MEM_writereg_num=8, MEM_mem_to_reg=1.
   - stall_cnt=1.
4. Flush: ID_flush=1 with a valid sw (memwrite=1) → EXE_memwrite=0, stall_cnt unchanged. Flush plus stall in the same cycle → one bubble, stall_cnt +1.
5. Counter saturation (CNT_W=4): hold ID_nostall=0 for 20 cycles → stall_cnt reaches 15 and stays 15. Assert rst → 0.
6. Reset mid-pipeline: three valid writes in flight (rd=1,2,3), assert rst for 1 cycle → all MEM_/WB_ fields are 0 on the next cycle, and no stale RegWrite appears afterward.

Source files
------------

// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: ID->EXE->MEM->WB control registers feeding hazard/forwarding logic, with bubble insertion and stall counter
module ctrl_pipe_regs #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_RegWrite,
  input  logic             ID_mem_to_reg,
  input  logic             ID_memwrite,
  input  logic             ID_jal,
  input  logic [1:0]       ID_writereg_to_rt,
  input  logic [4:0]       ID_rd,
  input  logic [4:0]       ID_rt,
  input  logic [3:0]       ID_aluOp,
  input  logic             ID_alua,
  input  logic             ID_alub,
  input  logic             ID_nostall,
  input  logic             ID_flush,
  output logic             EXE_RegWrite,
  output logic             EXE_mem_to_reg,
  output logic             EXE_memwrite,
  output logic             EXE_jal,
  output logic             EXE_alua,
  output logic             EXE_alub,
  output logic [3:0]       EXE_aluOp,
  output logic [4:0]       EXE_writereg_num,
  output logic             MEM_RegWrite,
  output logic             MEM_mem_to_reg,
  output logic             MEM_memwrite,
  output logic             MEM_jal,
  output logic [4:0]       MEM_writereg_num,
  output logic             WB_RegWrite,
  output logic             WB_mem_to_reg,
  output logic             WB_jal,
  output logic [4:0]       WB_writereg_num,
  output logic             IFID_we,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [4:0] dest_num;
  logic       bubble;
  always_comb begin
    dest_num = ID_writereg_to_rt == 2'b00 ? ID_rd :
               ID_writereg_to_rt == 2'b01 ? ID_rt :
               ID_writereg_to_rt == 2'b10 ? 5'd31 : 5'd0;
    bubble   = ID_flush | ~ID_nostall;
    IFID_we  = ID_nostall;
  end
  // A reserved select decodes to $0, so the nonzero test also kills its write
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      EXE_RegWrite     <= 1'b0;
      EXE_mem_to_reg   <= 1'b0;
      EXE_memwrite     <= 1'b0;
      EXE_jal          <= 1'b0;
      EXE_alua         <= 1'b0;
      EXE_alub         <= 1'b0;
      EXE_aluOp        <= 4'd0;
      EXE_writereg_num <= 5'd0;
    end else begin
      EXE_RegWrite     <= ID_RegWrite & (dest_num != 5'd0);
      EXE_mem_to_reg   <= ID_mem_to_reg;
      EXE_memwrite     <= ID_memwrite;
      EXE_jal          <= ID_jal;
      EXE_alua         <= ID_alua;
      EXE_alub         <= ID_alub;
      EXE_aluOp        <= ID_aluOp;
      EXE_writereg_num <= dest_num;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_RegWrite     <= 1'b0;
      MEM_mem_to_reg   <= 1'b0;
      MEM_memwrite     <= 1'b0;
      MEM_jal          <= 1'b0;
      MEM_writereg_num <= 5'd0;
      WB_RegWrite      <= 1'b0;
      WB_mem_to_reg    <= 1'b0;
      WB_jal           <= 1'b0;
      WB_writereg_num  <= 5'd0;
    end else begin
      MEM_RegWrite     <= EXE_RegWrite;
      MEM_mem_to_reg   <= EXE_mem_to_reg;
      MEM_memwrite     <= EXE_memwrite;
      MEM_jal          <= EXE_jal;
      MEM_writereg_num <= EXE_writereg_num;
      WB_RegWrite      <= MEM_RegWrite;
      WB_mem_to_reg    <= MEM_mem_to_reg;
      WB_jal           <= MEM_jal;
      WB_writereg_num  <= MEM_writereg_num;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (!ID_nostall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// tb_ctrl_pipe_regs: directed plus random checks of ctrl_pipe_regs against a stage-history model
module tb_ctrl_pipe_regs;
  logic clk = 0, rst = 1;
  logic ID_RegWrite = 0, ID_mem_to_reg = 0, ID_memwrite = 0, ID_jal = 0;
  logic [1:0] ID_writereg_to_rt = 0;
  logic [4:0] ID_rd = 0, ID_rt = 0;
  logic [3:0] ID_aluOp = 0;
  logic ID_alua = 0, ID_alub = 0, ID_nostall = 1, ID_flush = 0;
  logic EXE_RegWrite, EXE_mem_to_reg, EXE_memwrite, EXE_jal, EXE_alua, EXE_alub;
  logic [3:0] EXE_aluOp;
  logic [4:0] EXE_writereg_num, MEM_writereg_num, WB_writereg_num;
  logic MEM_RegWrite, MEM_mem_to_reg, MEM_memwrite, MEM_jal;
  logic WB_RegWrite, WB_mem_to_reg, WB_jal, IFID_we;
  logic [3:0] stall_cnt;
  int tests = 0, fails = 0;
  ctrl_pipe_regs #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ID_RegWrite(ID_RegWrite), .ID_mem_to_reg(ID_mem_to_reg), .ID_memwrite(ID_memwrite),
    .ID_jal(ID_jal), .ID_writereg_to_rt(ID_writereg_to_rt), .ID_rd(ID_rd), .ID_rt(ID_rt),
    .ID_aluOp(ID_aluOp), .ID_alua(ID_alua), .ID_alub(ID_alub),
    .ID_nostall(ID_nostall), .ID_flush(ID_flush),
    .EXE_RegWrite(EXE_RegWrite), .EXE_mem_to_reg(EXE_mem_to_reg), .EXE_memwrite(EXE_memwrite),
    .EXE_jal(EXE_jal), .EXE_alua(EXE_alua), .EXE_alub(EXE_alub), .EXE_aluOp(EXE_aluOp),
    .EXE_writereg_num(EXE_writereg_num),
    .MEM_RegWrite(MEM_RegWrite), .MEM_mem_to_reg(MEM_mem_to_reg), .MEM_memwrite(MEM_memwrite),
    .MEM_jal(MEM_jal), .MEM_writereg_num(MEM_writereg_num),
    .WB_RegWrite(WB_RegWrite), .WB_mem_to_reg(WB_mem_to_reg), .WB_jal(WB_jal),
    .WB_writereg_num(WB_writereg_num), .IFID_we(IFID_we), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    bit rw, m2r, mw, jal, alua, alub;
    bit [3:0] op;
    bit [4:0] num;
  } st_t;
  st_t pipe [3];
  int scnt = 0;
  bit started = 0;
  function automatic st_t model();
    st_t s = '0;
    bit [4:0] n;
    n = ID_writereg_to_rt == 0 ? ID_rd : ID_writereg_to_rt == 1 ? ID_rt :
        ID_writereg_to_rt == 2 ? 5'd31 : 5'd0;
    if (ID_nostall && !ID_flush) begin
      s.rw = ID_RegWrite && n != 0;
      s.m2r = ID_mem_to_reg; s.mw = ID_memwrite; s.jal = ID_jal;
      s.alua = ID_alua; s.alub = ID_alub; s.op = ID_aluOp; s.num = n;
    end
    return s;
  endfunction
  always @(posedge clk) begin
    started <= 1;
    if (rst) begin
      pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0; scnt <= 0;
    end else begin
      pipe[0] <= model(); pipe[1] <= pipe[0]; pipe[2] <= pipe[1];
      if (!ID_nostall) scnt <= scnt + 1 > 15 ? 15 : scnt + 1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (started) begin
    chk("exe", 32'({EXE_RegWrite, EXE_mem_to_reg, EXE_memwrite, EXE_jal, EXE_alua, EXE_alub,
                    EXE_aluOp, EXE_writereg_num}), 32'(pipe[0]));
    chk("mem", 32'({MEM_RegWrite, MEM_mem_to_reg, MEM_memwrite, MEM_jal, MEM_writereg_num}),
        32'({pipe[1].rw, pipe[1].m2r, pipe[1].mw, pipe[1].jal, pipe[1].num}));
    chk("wb", 32'({WB_RegWrite, WB_mem_to_reg, WB_jal, WB_writereg_num}),
        32'({pipe[2].rw, pipe[2].m2r, pipe[2].jal, pipe[2].num}));
    chk("ifid_we", 32'(IFID_we), 32'(ID_nostall));
    chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
  end
  task automatic put(input bit r, m2r, mw, jl, input bit [1:0] sel, input bit [4:0] rd, rt,
                     input bit ns, fl);
    #1;
    rst = 0; ID_RegWrite = r; ID_mem_to_reg = m2r; ID_memwrite = mw; ID_jal = jl;
    ID_writereg_to_rt = sel; ID_rd = rd; ID_rt = rt; ID_nostall = ns; ID_flush = fl;
    ID_aluOp = 4'($urandom); ID_alua = 1'($urandom); ID_alub = 1'($urandom);
    @(negedge clk);
  endtask
  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic do_rst(input int n);
    #1;
    rst = 1; ID_RegWrite = 1; ID_rd = 5'($urandom); ID_writereg_to_rt = 0;
    ID_nostall = 1'($urandom); ID_flush = 1'($urandom);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    do_rst(2);
    chk("rst_exe_num", 32'(EXE_writereg_num), 0);
    chk("rst_wb_rw", 32'(WB_RegWrite), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    put(1, 0, 0, 0, 0, 5, 7, 1, 0);
    chk("lat1_num", 32'(EXE_writereg_num), 5);
    chk("lat1_rw", 32'(EXE_RegWrite), 1);
    nop();
    chk("lat2_num", 32'(MEM_writereg_num), 5);
    nop();
    chk("lat3_num", 32'(WB_writereg_num), 5);
    chk("lat3_rw", 32'(WB_RegWrite), 1);
    put(1, 0, 0, 0, 1, 3, 9, 1, 0);
    chk("sel_rt", 32'(EXE_writereg_num), 9);
    put(1, 0, 0, 1, 2, 3, 9, 1, 0);
    chk("sel_31", 32'(EXE_writereg_num), 31);
    put(1, 0, 0, 0, 3, 3, 9, 1, 0);
    chk("sel_res", 32'({EXE_RegWrite, EXE_writereg_num}), 0);
    put(1, 0, 0, 0, 0, 0, 9, 1, 0);
    chk("rd0_rw", 32'(EXE_RegWrite), 0);
    put(1, 1, 0, 0, 1, 2, 8, 1, 0);
    #1;
    ID_RegWrite = 0; ID_nostall = 0;
    #1;
    chk("stall_ifid", 32'(IFID_we), 0);
    @(negedge clk);
    chk("stall_exe", 32'({EXE_RegWrite, EXE_mem_to_reg, EXE_writereg_num}), 0);
    chk("stall_mem", 32'({MEM_mem_to_reg, MEM_writereg_num}), 32'({1'b1, 5'd8}));
    chk("stall_cnt1", 32'(stall_cnt), 1);
    put(0, 0, 1, 0, 0, 0, 4, 1, 1);
    chk("flush_mw", 32'(EXE_memwrite), 0);
    chk("flush_cnt", 32'(stall_cnt), 1);
    put(1, 0, 1, 0, 0, 6, 4, 0, 1);
    chk("fs_exe", 32'({EXE_RegWrite, EXE_memwrite, EXE_writereg_num}), 0);
    chk("fs_cnt", 32'(stall_cnt), 2);
    repeat (20) put(1, 0, 0, 0, 0, 4, 4, 0, 0);
    chk("sat_cnt", 32'(stall_cnt), 15);
    do_rst(1);
    chk("sat_rst", 32'(stall_cnt), 0);
    nop();
    for (int i = 1; i <= 3; i++) put(1, 0, 0, 0, 0, 5'(i), 0, 1, 0);
    do_rst(1);
    chk("mid_rst", 32'({MEM_RegWrite, MEM_writereg_num, WB_RegWrite, WB_writereg_num}), 0);
    nop();
    chk("mid_rst_mem", 32'({MEM_RegWrite, WB_RegWrite}), 0);
    nop();
    chk("mid_rst_wb", 32'(WB_RegWrite), 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) do_rst(1);
      else put(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
               5'($urandom), 5'($urandom), $urandom_range(99) < 80, $urandom_range(99) < 10);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
